// File: rtl/ov_inf_pkg.sv
// Shared definitions for the OV sensor bring-up sequencer: FSM encoding,
// SCCB master status/action constants and the default sensor init table.
package ov_inf_pkg;

   typedef enum logic [4:0] {
      S_IDLE  = 5'd0,
      S_PWAIT = 5'd1,
      S_LOAD  = 5'd2,
      S_KICK  = 5'd3,
      S_WBUSY = 5'd4,
      S_WDONE = 5'd5,
      S_CHK   = 5'd6,
      S_GAP   = 5'd7,
      S_DLY   = 5'd8,
      S_DONE  = 5'd9,
      S_ERR   = 5'd10
   } state_t;

   localparam int         ST_BUSY  = 0;
   localparam int         ST_NACK  = 1;
   localparam logic [7:0] ACT_KICK = 8'h03;
   localparam logic [7:0] DLY_ADDR = 8'hFF;

   // pluse_us ticks per millisecond of a delay entry
   localparam logic [15:0] MS_TICKS = 16'd1000;

   // Entry i sits at bits [16*i +: 16] as {addr, data}
   localparam int TBL_DEPTH = 256;
   typedef logic [TBL_DEPTH-1:0][15:0] reg_tbl_t;

   localparam reg_tbl_t DEF_TBL = {
      {(TBL_DEPTH-16){16'h0000}},
      16'h1502, 16'h13E7, 16'h3A04, 16'h8C00,
      16'h40D0, 16'h1214, 16'hA202, 16'h73F1,
      16'h7211, 16'h7135, 16'h703A, 16'h3E19,
      16'h0C04, 16'h1101, 16'hFF01, 16'h1280
   };

endpackage

// File: rtl/ov_init_seq_if.sv
// Config/action/status bundle between the init sequencer and the SCCB master.
interface ov_init_seq_if;

   logic [7:0] cfg_iic_devid;
   logic [7:0] cfg_iic_addr;
   logic [7:0] cfg_iic_wdata;
   logic [7:0] act_iic_write;
   logic [7:0] act_iic_read;
   logic [7:0] stu_iic_status;

   modport master (
      output cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata,
      output act_iic_write, act_iic_read,
      input  stu_iic_status
   );

   modport slave (
      input  cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata,
      input  act_iic_write, act_iic_read,
      output stu_iic_status
   );

endinterface

// File: rtl/ov_reg_rom.sv
// Sensor init table lookup; swap the table through TBL without touching the FSM.
module ov_reg_rom
   import ov_inf_pkg::*;
#(
   parameter reg_tbl_t TBL = DEF_TBL
) (
   input  logic [7:0] idx,
   output logic [7:0] addr,
   output logic [7:0] data
);

   assign {addr, data} = TBL[idx];

endmodule

// File: rtl/ov_init_seq.sv
// Camera bring-up sequencer: walks the register table, kicks one SCCB write per
// entry, retries on NACK/timeout and reports sticky done/error.
module ov_init_seq
   import ov_inf_pkg::*;
#(
   parameter logic [7:0] DEVID     = 8'h42,
   parameter int         NUM_REGS  = 16,
   parameter int         PWR_US    = 1000,
   parameter int         GAP_US    = 10,
   parameter int         TOUT_US   = 2000,
   parameter int         MAX_RETRY = 2,
   parameter reg_tbl_t   TBL       = DEF_TBL
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic          pluse_us,
   input  logic          start,
   ov_init_seq_if.master iic,
   output logic          init_done,
   output logic          init_err,
   output logic [7:0]    cur_idx
);

   localparam logic [15:0] PWR_TICKS  = 16'(PWR_US);
   localparam logic [15:0] GAP_TICKS  = 16'(GAP_US);
   localparam logic [15:0] TOUT_TICKS = 16'(TOUT_US);
   localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);
   localparam logic [7:0]  LAST_IDX   = 8'(NUM_REGS - 1);

   state_t      state;
   logic [15:0] tick;
   logic        start_d;
   logic [7:0]  retry;
   logic [7:0]  dly_ms;
   logic        nack_l;
   logic        good;
   logic [7:0]  cfg_addr;
   logic [7:0]  cfg_wdata;
   logic [7:0]  act_write;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic        start_edge;
   logic        busy;

   assign start_edge = start & ~start_d;
   assign busy       = iic.stu_iic_status[ST_BUSY];

   ov_reg_rom #(.TBL(TBL)) u_rom (
      .idx  (cur_idx),
      .addr (rom_addr),
      .data (rom_data)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin : fsm
      state_t nxt;
      if (!rst_n) begin
         state     <= S_IDLE;
         tick      <= '0;
         start_d   <= 1'b0;
         retry     <= '0;
         dly_ms    <= '0;
         nack_l    <= 1'b0;
         good      <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         act_write <= '0;
         init_done <= 1'b0;
         init_err  <= 1'b0;
         cur_idx   <= '0;
      end else begin
         // NOTE: nxt is a blocking scratch variable local to this block; every
         // register it feeds is still updated with <= below.
         nxt       = state;
         start_d   <= start;
         act_write <= 8'h00;

         unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_edge) begin
                  init_done <= 1'b0;
                  init_err  <= 1'b0;
                  cur_idx   <= '0;
                  retry     <= '0;
                  nxt       = S_PWAIT;
               end
            end
            S_PWAIT: if (tick == PWR_TICKS) nxt = S_LOAD;
            S_LOAD: begin
               if (rom_addr == DLY_ADDR) begin
                  dly_ms <= rom_data;
                  nxt    = S_DLY;
               end else begin
                  cfg_addr  <= rom_addr;
                  cfg_wdata <= rom_data;
                  nxt       = S_KICK;
               end
            end
            // Config was loaded a cycle earlier, so the kick lands on stable data
            S_KICK: begin
               act_write <= ACT_KICK;
               nxt       = S_WBUSY;
            end
            S_WBUSY: begin
               if (busy) begin
                  nxt = S_WDONE;
               end else if (tick == TOUT_TICKS) begin
                  nack_l <= 1'b1;
                  nxt    = S_CHK;
               end
            end
            // A busy fall outranks a timeout in the same cycle
            S_WDONE: begin
               if (!busy) begin
                  nack_l <= iic.stu_iic_status[ST_NACK];
                  nxt    = S_CHK;
               end else if (tick == TOUT_TICKS) begin
                  nack_l <= 1'b1;
                  nxt    = S_CHK;
               end
            end
            S_CHK: begin
               if (!nack_l) begin
                  good <= 1'b1;
                  nxt  = S_GAP;
               end else if (retry < RETRY_MAX) begin
                  retry <= retry + 8'd1;
                  good  <= 1'b0;
                  nxt   = S_GAP;
               end else begin
                  init_err <= 1'b1;
                  nxt      = S_ERR;
               end
            end
            S_GAP: begin
               if (tick == GAP_TICKS) begin
                  if (!good) begin
                     nxt = S_LOAD;
                  end else if (cur_idx == LAST_IDX) begin
                     init_done <= 1'b1;
                     nxt       = S_DONE;
                  end else begin
                     cur_idx <= cur_idx + 8'd1;
                     retry   <= '0;
                     nxt     = S_LOAD;
                  end
               end
            end
            // Milliseconds are counted separately so long delays fit the 16-bit tick
            S_DLY: begin
               if (dly_ms == 8'd0) begin
                  good <= 1'b1;
                  nxt  = S_GAP;
               end else if (pluse_us && tick == MS_TICKS - 16'd1) begin
                  dly_ms <= dly_ms - 8'd1;
               end
            end
            default: nxt = S_IDLE;
         endcase

         if (nxt != state)
            tick <= '0;
         else if (pluse_us && state == S_DLY && tick == MS_TICKS - 16'd1)
            tick <= '0;
         else if (pluse_us && tick != 16'hFFFF)
            tick <= tick + 16'd1;

         state <= nxt;
      end
   end

   assign iic.cfg_iic_devid = DEVID;
   assign iic.cfg_iic_addr  = cfg_addr;
   assign iic.cfg_iic_wdata = cfg_wdata;
   assign iic.act_iic_write = act_write;
   assign iic.act_iic_read  = 8'h00;

endmodule
